// File: rtl/panel_write_arbiter.sv
// Two-requester pixel write arbiter for the shared panel control bus.
// Optional clear sequencer is built when PANEL_ARB_CLEAR_EN is defined.
module panel_write_arbiter #(
    parameter int NUM_PANELS = 4,
    parameter int PIXELS     = 4096
) (
    input  logic        display_clock,
    input  logic        display_reset_n,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [7:0]  s0_panel,
    input  logic [15:0] s0_addr,
    input  logic [15:0] s0_data,
    input  logic        s0_last,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [7:0]  s1_panel,
    input  logic [15:0] s1_addr,
    input  logic [15:0] s1_data,
    input  logic        s1_last,
`ifdef PANEL_ARB_CLEAR_EN
    input  logic        clear_start,
    input  logic [15:0] clear_color,
    output logic        clear_busy,
    output logic        clear_done,
`endif
    output logic [7:0]  ctrl_en,
    output logic [15:0] ctrl_addr,
    output logic [15:0] ctrl_wdat,
    output logic [15:0] drop_count
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1
`ifdef PANEL_ARB_CLEAR_EN
        , CLEAR
`endif
    } state_t;

    localparam logic [7:0]  MAX_PANEL = 8'(NUM_PANELS);
    localparam logic [16:0] PIX_LIMIT = 17'(PIXELS);

    state_t state;
    logic   last_served;

    logic s0_ok;
    logic s1_ok;
    logic s0_take;
    logic s1_take;
    logic drop;

    assign s0_ok = (s0_panel != 8'd0) && (s0_panel <= MAX_PANEL)
                   && ({1'b0, s0_addr} < PIX_LIMIT);
    assign s1_ok = (s1_panel != 8'd0) && (s1_panel <= MAX_PANEL)
                   && ({1'b0, s1_addr} < PIX_LIMIT);

    assign s0_take = s0_valid && s0_ready;
    assign s1_take = s1_valid && s1_ready;
    assign drop    = (s0_take && !s0_ok) || (s1_take && !s1_ok);

`ifdef PANEL_ARB_CLEAR_EN
    localparam logic [15:0] LAST_ADDR = 16'(PIXELS - 1);

    logic        clear_pend;
    logic [15:0] clear_col_q;
    logic [7:0]  clr_panel;
    logic [15:0] clr_addr;
    logic        clear_take;
    logic        clear_req;
    logic [15:0] clear_fill;
    logic        clr_wrap;
    logic        clr_final;
    logic [7:0]  nxt_panel;
    logic [15:0] nxt_addr;

    // A start arriving in IDLE itself is honoured without the pending hop
    assign clear_take = clear_start && !clear_pend && !clear_busy;
    assign clear_req  = clear_pend || clear_take;
    assign clear_fill = clear_pend ? clear_col_q : clear_color;

    assign clr_wrap  = clr_addr == LAST_ADDR;
    assign clr_final = clr_wrap && (clr_panel == MAX_PANEL);
    assign nxt_panel = clr_wrap ? clr_panel + 8'd1 : clr_panel;
    assign nxt_addr  = clr_wrap ? 16'd0 : clr_addr + 16'd1;
`endif

    always_ff @(posedge display_clock) begin
        if (!display_reset_n) begin
            state       <= IDLE;
            last_served <= 1'b1;
            s0_ready    <= 1'b0;
            s1_ready    <= 1'b0;
            ctrl_en     <= 8'd0;
            ctrl_addr   <= 16'd0;
            ctrl_wdat   <= 16'd0;
            drop_count  <= 16'd0;
`ifdef PANEL_ARB_CLEAR_EN
            clear_pend  <= 1'b0;
            clear_col_q <= 16'd0;
            clr_panel   <= 8'd0;
            clr_addr    <= 16'd0;
            clear_busy  <= 1'b0;
            clear_done  <= 1'b0;
`endif
        end else begin
            ctrl_en <= 8'd0;
            if (drop && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
`ifdef PANEL_ARB_CLEAR_EN
            clear_done <= 1'b0;
            if (clear_take) begin
                clear_pend  <= 1'b1;
                clear_col_q <= clear_color;
            end
`endif
            unique case (state)
                IDLE: begin
`ifdef PANEL_ARB_CLEAR_EN
                    if (clear_req) begin
                        state       <= CLEAR;
                        clear_pend  <= 1'b0;
                        clear_busy  <= 1'b1;
                        clear_col_q <= clear_fill;
                        clr_panel   <= 8'd1;
                        clr_addr    <= 16'd0;
                        ctrl_en     <= 8'd1;
                        ctrl_addr   <= 16'd0;
                        ctrl_wdat   <= clear_fill;
                    end else
`endif
                    if (s0_valid && (!s1_valid || last_served)) begin
                        state    <= GRANT0;
                        s0_ready <= 1'b1;
                    end else if (s1_valid) begin
                        state    <= GRANT1;
                        s1_ready <= 1'b1;
                    end
                end
                GRANT0: begin
                    if (s0_take) begin
                        if (s0_ok) begin
                            ctrl_en   <= s0_panel;
                            ctrl_addr <= s0_addr;
                            ctrl_wdat <= s0_data;
                        end
                        if (s0_last) begin
                            state       <= IDLE;
                            s0_ready    <= 1'b0;
                            last_served <= 1'b0;
                        end
                    end
                end
                GRANT1: begin
                    if (s1_take) begin
                        if (s1_ok) begin
                            ctrl_en   <= s1_panel;
                            ctrl_addr <= s1_addr;
                            ctrl_wdat <= s1_data;
                        end
                        if (s1_last) begin
                            state       <= IDLE;
                            s1_ready    <= 1'b0;
                            last_served <= 1'b1;
                        end
                    end
                end
`ifdef PANEL_ARB_CLEAR_EN
                CLEAR: begin
                    if (clr_final) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        clr_panel <= nxt_panel;
                        clr_addr  <= nxt_addr;
                        ctrl_en   <= nxt_panel;
                        ctrl_addr <= nxt_addr;
                        ctrl_wdat <= clear_col_q;
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    s0_ready <= 1'b0;
                    s1_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
